// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and widths for the memory bus interface.
package mem_bus_pkg;
   localparam int WORD_W = 16;
   localparam int WAIT_W = 4;
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} mem_state_t;
endpackage

// File: rtl/reg16_ld.sv
// reg16_ld: 16-bit register with synchronous active-low reset and load enable.
module reg16_ld
   import mem_bus_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ld,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);
   always_ff @(posedge Clk)
      q <= !Reset ? '0 : ld ? d : q;
endmodule

// File: rtl/mem_bus_interface.sv
// mem_bus_interface: MAR/MDR bus source running wait-stated async SRAM read/write cycles.
// Optional MEM_STATS_EN adds rd_count/wr_count completion counters.
module mem_bus_interface
   import mem_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_ADDR_W = 20
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [WORD_W-1:0]      bus_in,
   input  logic                   LD_MAR,
   input  logic                   LD_MDR,
   input  logic                   GateMDR,
   input  logic                   mem_req,
   input  logic                   mem_we,
   output logic                   mem_ready,
   output logic                   mem_busy,
   output logic [WORD_W-1:0]      bus_out,
   output logic                   bus_drive,
`ifdef MEM_STATS_EN
   output logic [15:0]            rd_count,
   output logic [15:0]            wr_count,
`endif
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   input  logic [WORD_W-1:0]      sram_data_in,
   output logic [WORD_W-1:0]      sram_data_out,
   output logic                   sram_data_oe,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n
);
   mem_state_t state, state_nxt;
   logic [WAIT_W-1:0] cnt;
   logic we_lat, we_nxt, idle, cap;
   logic [WORD_W-1:0] mar, mdr;
   assign idle   = state == IDLE;
   assign cap    = state == ACCESS && cnt == '0 && !we_lat;
   assign we_nxt = idle && mem_req ? mem_we : we_lat;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = mem_req ? SETUP : IDLE;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  state_nxt = cnt != '0 ? ACCESS : we_lat ? HOLD : DONE;
         HOLD:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   // Strobes are decoded from the next state so they are registered yet aligned with it
   always_ff @(posedge Clk)
      if (!Reset) begin
         state        <= IDLE;
         cnt          <= '0;
         we_lat       <= 1'b0;
         mem_ready    <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_data_oe <= 1'b0;
      end else begin
         state        <= state_nxt;
         we_lat       <= we_nxt;
         cnt          <= state == SETUP ? WAIT_W'(WAIT_CYCLES - 1) : (state == ACCESS && cnt != '0) ? cnt - 1'b1 : cnt;
         mem_ready    <= state_nxt == DONE;
         sram_ce_n    <= !(state_nxt inside {SETUP, ACCESS, HOLD});
         sram_oe_n    <= !(!we_nxt && state_nxt inside {SETUP, ACCESS});
         sram_we_n    <= !(we_nxt && state_nxt == ACCESS);
         sram_data_oe <= we_nxt && state_nxt inside {SETUP, ACCESS, HOLD};
      end
   reg16_ld u_mar (.Clk(Clk), .Reset(Reset), .ld(LD_MAR && idle), .d(bus_in), .q(mar));
   reg16_ld u_mdr (.Clk(Clk), .Reset(Reset), .ld(cap || (LD_MDR && idle)), .d(cap ? sram_data_in : bus_in), .q(mdr));
   assign mem_busy      = !idle;
   assign bus_out       = GateMDR ? mdr : '0;
   assign bus_drive     = GateMDR;
   assign sram_addr     = SRAM_ADDR_W'(mar);
   assign sram_data_out = mdr;
`ifdef MEM_STATS_EN
   always_ff @(posedge Clk)
      if (!Reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (state == DONE) begin
         rd_count <= rd_count + 16'(!we_lat);
         wr_count <= wr_count + 16'(we_lat);
      end
`endif
endmodule

// File: tb/tb_mem_bus_interface.sv
// tb_mem_bus_interface: directed bench with a completion scoreboard and per-cycle strobe checks.
module tb_mem_bus_interface;
   localparam int W = 2;
   logic Clk = 1'b0, Reset = 1'b0;
   logic [15:0] bus_in = '0;
   logic LD_MAR = 1'b0, LD_MDR = 1'b0, GateMDR = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic mem_ready, mem_busy, bus_drive, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic [15:0] bus_out, sram_data_in, sram_data_out;
   logic [19:0] sram_addr;
`ifdef MEM_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif
   logic [15:0] sram [0:255];
   logic [15:0] exp_mem [0:255];
   logic [35:0] sb [$];
   logic [35:0] sb_exp;
   logic [15:0] mar_m = '0, mdr_m = '0;
   int n_vec = 0, n_err = 0;

   mem_bus_interface #(.WAIT_CYCLES(W), .SRAM_ADDR_W(20)) dut (
      .Clk(Clk), .Reset(Reset), .bus_in(bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
      .GateMDR(GateMDR), .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
      .mem_busy(mem_busy), .bus_out(bus_out), .bus_drive(bus_drive),
`ifdef MEM_STATS_EN
      .rd_count(rd_count), .wr_count(wr_count),
`endif
      .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
      .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   always #5 Clk = ~Clk;

   // Async SRAM model; DEAD outside an enabled read exposes mistimed captures
   assign sram_data_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[7:0]] : 16'hDEAD;
   always @(posedge Clk)
      if (!sram_ce_n && !sram_we_n && sram_data_oe) sram[sram_addr[7:0]] <= sram_data_out;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge Clk)
      if (mem_ready) begin
         if (sb.size() == 0) chk("unexpected_ready", 36'(mem_ready), 36'h0);
         else begin
            sb_exp = sb.pop_front();
            chk("sb_result", {sram_addr, sram_data_out}, sb_exp);
         end
      end

   function automatic logic [5:0] exp_rd(input int j);
      if (j >= 1 && j <= W + 1) return 6'b001001;
      if (j == W + 2) return 6'b111011;
      return 6'b111000;
   endfunction

   function automatic logic [5:0] exp_wr(input int j);
      if (j == 1 || j == W + 2) return 6'b011101;
      if (j >= 2 && j <= W + 1) return 6'b010101;
      if (j == W + 3) return 6'b111011;
      return 6'b111000;
   endfunction

   function automatic logic [35:0] strobes();
      return 36'({sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, mem_ready, mem_busy});
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic ld(input bit is_mar, input logic [15:0] v);
      bus_in = v;
      LD_MAR = is_mar;
      LD_MDR = !is_mar;
      tick();
      LD_MAR = 1'b0;
      LD_MDR = 1'b0;
      if (is_mar) mar_m = v; else mdr_m = v;
      chk("ld_addr", 36'(sram_addr), 36'(mar_m));
      chk("ld_mdr", 36'(sram_data_out), 36'(mdr_m));
   endtask

   task automatic run(input logic we, input bit lock);
      logic [15:0] old_mdr;
      old_mdr = mdr_m;
      if (we) exp_mem[mar_m[7:0]] = mdr_m;
      else mdr_m = exp_mem[mar_m[7:0]];
      sb.push_back({4'h0, mar_m, mdr_m});
      mem_req = 1'b1;
      mem_we = we;
      GateMDR = 1'b1;
      tick();
      mem_req = 1'b0;
      for (int j = 1; j <= W + 4; j++) begin
         chk(we ? "wr_strobes" : "rd_strobes", strobes(), 36'(we ? exp_wr(j) : exp_rd(j)));
         chk("acc_addr", 36'(sram_addr), 36'(mar_m));
         chk("acc_bus_out", 36'(bus_out), 36'((!we && j >= W + 2) ? mdr_m : old_mdr));
         if (we && sram_data_oe) chk("wr_data", 36'(sram_data_out), 36'(mdr_m));
         if (lock && j == 2) begin bus_in = 16'h0020; LD_MAR = 1'b1; end
         if (lock && j == 3) begin bus_in = 16'h1234; LD_MAR = 1'b0; LD_MDR = 1'b1; end
         if (lock && j == 4) LD_MDR = 1'b0;
         tick();
      end
      GateMDR = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
      repeat (2) begin
         bus_in = 16'($urandom);
         {LD_MAR, LD_MDR, GateMDR, mem_req, mem_we} = 5'($urandom);
         tick();
      end
      chk("rst_strobes", strobes(), 36'b111000);
      chk("rst_addr", 36'(sram_addr), 36'h0);
      chk("rst_mdr", 36'(sram_data_out), 36'h0);
      chk("rst_bus_out", 36'(bus_out), 36'h0);
      {LD_MAR, LD_MDR, GateMDR, mem_req, mem_we} = '0;
      Reset = 1'b1;
      tick();
      ld(1'b1, 16'h0010);
      ld(1'b0, 16'hBEEF);
      chk("wr_addr20", 36'(sram_addr), 36'h00010);
      run(1'b1, 1'b0);
      ld(1'b0, 16'h0000);
      run(1'b0, 1'b0);
      GateMDR = 1'b1;
      #1;
      chk("gate_bus_out", 36'(bus_out), 36'hBEEF);
      chk("gate_drive", 36'(bus_drive), 36'h1);
      GateMDR = 1'b0;
      #1;
      chk("ungate_bus_out", 36'(bus_out), 36'h0);
      chk("ungate_drive", 36'(bus_drive), 36'h0);
      ld(1'b0, 16'h5555);
      run(1'b0, 1'b1);
      chk("lock_mar", 36'(sram_addr), 36'h00010);
      chk("lock_mdr", 36'(sram_data_out), 36'hBEEF);
      // Back-to-back reads with mem_req held through the first DONE
      mdr_m = exp_mem[8'h10];
      sb.push_back({4'h0, mar_m, mdr_m});
      sb.push_back({4'h0, mar_m, mdr_m});
      mem_req = 1'b1;
      mem_we = 1'b0;
      tick();
      for (int j = 1; j <= 2 * W + 6; j++) begin
         chk("b2b_strobes", strobes(), 36'(j <= W + 2 ? exp_rd(j) : exp_rd(j - (W + 3))));
         if (j == 2 * W + 5) mem_req = 1'b0;
         tick();
      end
      // Abort a write mid-ACCESS
      ld(1'b1, 16'h0030);
      ld(1'b0, 16'hCAFE);
      mem_req = 1'b1;
      mem_we = 1'b1;
      tick();
      mem_req = 1'b0;
      tick();
      chk("abort_pre_we_n", 36'(sram_we_n), 36'h0);
      Reset = 1'b0;
      tick();
      chk("abort_strobes", strobes(), 36'b111000);
      chk("abort_addr", 36'(sram_addr), 36'h0);
      chk("abort_mdr", 36'(sram_data_out), 36'h0);
      Reset = 1'b1;
      mar_m = '0;
      mdr_m = '0;
`ifdef MEM_STATS_EN
      chk("abort_wr_count", 36'(wr_count), 36'h0);
`endif
      repeat (4) tick();
      chk("abort_idle", strobes(), 36'b111000);
      ld(1'b1, 16'h0040);
      ld(1'b0, 16'h7777);
      run(1'b1, 1'b0);
      ld(1'b0, 16'h0000);
      run(1'b0, 1'b0);
      chk("final_mdr", 36'(sram_data_out), 36'h7777);
`ifdef MEM_STATS_EN
      chk("wr_count", 36'(wr_count), 36'h1);
      chk("rd_count", 36'(rd_count), 36'h1);
`endif
      tick();
      chk("sb_drained", 36'(sb.size()), 36'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
- Memory-side bus source for the 16-bit datapath.
- Holds MAR and MDR and runs read/write cycles to the external asynchronous SRAM with a programmable number of wait states.
- Drives MDR onto the shared bus when gated. This is the bus producer whose data the register file and other bus consumers load.
- Sits between the control FSM (load/gate/request strobes) and the SRAM pins.

Parameters:
- WAIT_CYCLES, 2, SRAM access-strobe cycles per access; legal range 1..15.
- SRAM_ADDR_W, 20, SRAM address width; MAR is zero-extended to this width.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- bus_in  input  16  current bus value, source for MAR/MDR loads.
- LD_MAR  input  1  load MAR from bus_in.
- LD_MDR  input  1  load MDR from bus_in.
- GateMDR  input  1  drive MDR onto the bus.
- mem_req  input  1  level request to start an access.
- mem_we  input  1  access type sampled with mem_req: 1 = write, 0 = read.
- mem_ready  output  1  one-cycle pulse when an access completes.
- mem_busy  output  1  high in every state except IDLE.
- bus_out  output  16  MDR when GateMDR=1, else 16'h0000.
- bus_drive  output  1  equals GateMDR.
- sram_addr  output  SRAM_ADDR_W  {zeros, MAR}.
- sram_data_in  input  16  read data from SRAM.
- sram_data_out  output  16  write data (MDR).
- sram_data_oe  output  1  enables the write-data pin driver.
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - MAR=0, MDR=0, wait counter=0, state=IDLE.
  - mem_ready=0, mem_busy=0, sram_data_oe=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - A reset mid-access aborts the access with all strobes inactive from the next cycle. No completion pulse is generated.
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE. All SRAM strobes are registered outputs.
- IDLE:
  - LD_MAR loads MAR. LD_MDR loads MDR.
  - If mem_req=1, latch mem_we and go to SETUP.
  - If LD_MAR, LD_MDR and mem_req coincide, the loads take effect and the access uses the new MAR/MDR from SETUP onward.
- SETUP (1 cycle):
  - ce_n=0.
  - Read: oe_n=0.
  - Write: data_oe=1.
  - Next state ACCESS; counter loaded with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - Read: ce_n=0, oe_n=0. At the edge ending the final ACCESS cycle, MDR <= sram_data_in; next state DONE.
  - Write: ce_n=0, we_n=0, data_oe=1. Next state HOLD.
- HOLD (write only, 1 cycle): ce_n=0, we_n=1, data_oe=1 (data hold). Next state DONE.
- DONE (1 cycle): all strobes inactive, mem_ready=1. Next state IDLE.
- Latency, with mem_req sampled at edge k:
  - Read: mem_ready high in cycle k+2+WAIT_CYCLES.
  - Write: mem_ready high in cycle k+3+WAIT_CYCLES.
- mem_req is level-sensitive and sampled only in IDLE. If it is still high in the IDLE cycle after DONE, a new access starts. The requester drops mem_req on mem_ready.
- LD_MAR/LD_MDR while mem_busy=1 are ignored; MAR/MDR are stable for the whole access.
- bus_out/bus_drive are combinational from GateMDR and MDR. GateMDR during a read access presents the old MDR until the capture edge.
- Arithmetic: wait counter width 4, down-count only, no wrap. Address zero-extension only, no sign extension.

Optional Feature:
- Macro MEM_STATS_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments by 1 on every DONE of its type.
  - Wraps 16'hFFFF -> 16'h0000.
  - Cleared by Reset.
  - Aborted accesses are not counted.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package mem_bus_pkg:
  - enum mem_state_t {IDLE, SETUP, ACCESS, HOLD, DONE}.
  - Constants WORD_W=16 and WAIT_W=4.
- Sub-module: one natural sub-module, reg16_ld (16-bit register with synchronous active-low reset and load enable), instantiated for MAR and MDR.
- The FSM and strobe generation stay in the top.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with random inputs -> ce_n/oe_n/we_n=1, data_oe=0, mem_ready=0, mem_busy=0, MAR=MDR=0, bus_out=0.
- Write, WAIT_CYCLES=2:
  - Stimulus: load MAR=16'h0010, MDR=16'hBEEF, pulse mem_req with mem_we=1 at edge k.
  - Required: sram_addr=20'h00010; we_n low exactly cycles k+2..k+3; data_oe high k+1..k+4 with sram_data_out=16'hBEEF; mem_ready pulse only at k+5.
- Read: sram model returns 16'hBEEF at 20'h00010; mem_req with mem_we=0 at edge k -> oe_n low k+1..k+3, mem_ready at k+4, MDR=16'hBEEF; GateMDR=1 -> bus_out=16'hBEEF, bus_drive=1.
- Busy lockout: during a read of 0x0010, assert LD_MAR with bus_in=16'h0020 and LD_MDR with bus_in=16'h1234 -> MAR stays 16'h0010; MDR ends as the read data, not 16'h1234.
- Back-to-back: hold mem_req=1 through DONE -> second access SETUP starts 1 cycle after the IDLE cycle; two mem_ready pulses with no strobe overlap.
- Reset mid-write:
  - Stimulus: Reset=0 during ACCESS.
  - Required: we_n=1 and data_oe=0 next cycle; no mem_ready; MAR=MDR=0.
  - With MEM_STATS_EN: wr_count unchanged by the abort; a later full write and read give wr_count=1, rd_count=1.
